// File: rtl/ram_wb.sv
// Write-back register file: eight 16-bit words plus a single-entry output port
// with valid/acknowledge handshake, sticky overrun flag and an accepted-write counter.
module ram_wb #(
    parameter logic [7:0] IO_OUT_AD = 8'b0100_0000
) (
    input  logic        CLK_WB,
    input  logic        RESET_N,
    input  logic [7:0]  RAM_AD_IN,
    input  logic [15:0] RAM_IN,
    input  logic        RAM_WEN,
    input  logic        IO64_ACK,
    output logic [15:0] RAM_0,
    output logic [15:0] RAM_1,
    output logic [15:0] RAM_2,
    output logic [15:0] RAM_3,
    output logic [15:0] RAM_4,
    output logic [15:0] RAM_5,
    output logic [15:0] RAM_6,
    output logic [15:0] RAM_7,
    output logic [15:0] IO64_OUT,
    output logic        IO64_VLD,
    output logic        IO64_OVR,
    output logic [7:0]  WR_CNT
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      state_reg;
    logic [15:0] io_out_reg;
    logic        io_vld_reg;
    logic        io_ovr_reg;
    logic [7:0]  wr_cnt_reg;

    logic        word_hit;
    logic        port_hit;
    logic        port_accept;
    logic        port_drop;
    logic [15:0] word_q [8];

    assign word_hit    = RAM_WEN && (RAM_AD_IN[7:3] == 5'd0);
    assign port_hit    = RAM_WEN && (RAM_AD_IN == IO_OUT_AD);
    // A port write is taken when the holding register is empty or being drained this cycle.
    assign port_accept = port_hit && ((state_reg == IDLE) || IO64_ACK);
    assign port_drop   = port_hit && (state_reg == HOLD) && !IO64_ACK;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : gen_word
            logic [15:0] word_reg;

            always_ff @(posedge CLK_WB or negedge RESET_N) begin
                if (!RESET_N) begin
                    word_reg <= '0;
                end else if (word_hit && (RAM_AD_IN[2:0] == 3'(gi))) begin
                    word_reg <= RAM_IN;
                end
            end

            assign word_q[gi] = word_reg;
        end
    endgenerate

    always_ff @(posedge CLK_WB or negedge RESET_N) begin
        if (!RESET_N) begin
            state_reg  <= IDLE;
            io_out_reg <= '0;
            io_vld_reg <= 1'b0;
            io_ovr_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (port_hit) begin
                        io_out_reg <= RAM_IN;
                        io_vld_reg <= 1'b1;
                        state_reg  <= HOLD;
                    end
                end
                HOLD: begin
                    if (port_accept) begin
                        io_out_reg <= RAM_IN;
                    end else if (IO64_ACK) begin
                        io_vld_reg <= 1'b0;
                        state_reg  <= IDLE;
                    end else if (port_drop) begin
                        io_ovr_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    io_vld_reg <= 1'b0;
                end
            endcase
        end
    end

    // Counter wraps naturally at 8 bits.
    always_ff @(posedge CLK_WB or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_cnt_reg <= '0;
        end else if (word_hit || port_accept) begin
            wr_cnt_reg <= wr_cnt_reg + 8'd1;
        end
    end

    assign RAM_0    = word_q[0];
    assign RAM_1    = word_q[1];
    assign RAM_2    = word_q[2];
    assign RAM_3    = word_q[3];
    assign RAM_4    = word_q[4];
    assign RAM_5    = word_q[5];
    assign RAM_6    = word_q[6];
    assign RAM_7    = word_q[7];
    assign IO64_OUT = io_out_reg;
    assign IO64_VLD = io_vld_reg;
    assign IO64_OVR = io_ovr_reg;
    assign WR_CNT   = wr_cnt_reg;

endmodule

// File: tb/tb_ram_wb.sv
// Directed bench for ram_wb: word writes, output-port handshake, overrun,
// asynchronous reset and counter wrap, checked with immediate assertions.
module tb_ram_wb;

    logic        CLK_WB = 1'b0;
    logic        RESET_N = 1'b1;
    logic [7:0]  RAM_AD_IN = '0;
    logic [15:0] RAM_IN = '0;
    logic        RAM_WEN = 1'b0;
    logic        IO64_ACK = 1'b0;
    logic [15:0] RAM_0, RAM_1, RAM_2, RAM_3, RAM_4, RAM_5, RAM_6, RAM_7;
    logic [15:0] IO64_OUT;
    logic        IO64_VLD;
    logic        IO64_OVR;
    logic [7:0]  WR_CNT;

    int n_assert = 0;
    int n_fail   = 0;
    logic [15:0] ram_obs [8];
    logic [15:0] ram_exp [8];

    ram_wb #(.IO_OUT_AD(8'd64)) dut (
        .CLK_WB(CLK_WB), .RESET_N(RESET_N),
        .RAM_AD_IN(RAM_AD_IN), .RAM_IN(RAM_IN), .RAM_WEN(RAM_WEN), .IO64_ACK(IO64_ACK),
        .RAM_0(RAM_0), .RAM_1(RAM_1), .RAM_2(RAM_2), .RAM_3(RAM_3),
        .RAM_4(RAM_4), .RAM_5(RAM_5), .RAM_6(RAM_6), .RAM_7(RAM_7),
        .IO64_OUT(IO64_OUT), .IO64_VLD(IO64_VLD), .IO64_OVR(IO64_OVR), .WR_CNT(WR_CNT)
    );

    always #5 CLK_WB = ~CLK_WB;

    assign ram_obs[0] = RAM_0;
    assign ram_obs[1] = RAM_1;
    assign ram_obs[2] = RAM_2;
    assign ram_obs[3] = RAM_3;
    assign ram_obs[4] = RAM_4;
    assign ram_obs[5] = RAM_5;
    assign ram_obs[6] = RAM_6;
    assign ram_obs[7] = RAM_7;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_port(input string tag, input logic [15:0] out_e, input logic vld_e,
                              input logic ovr_e, input logic [7:0] cnt_e);
        check({tag, " IO64_OUT"}, IO64_OUT, out_e);
        check({tag, " IO64_VLD"}, {15'd0, IO64_VLD}, {15'd0, vld_e});
        check({tag, " IO64_OVR"}, {15'd0, IO64_OVR}, {15'd0, ovr_e});
        check({tag, " WR_CNT"}, {8'd0, WR_CNT}, {8'd0, cnt_e});
        $display("%0t %s: out=%h vld=%b ovr=%b cnt=%0d", $time, tag, IO64_OUT, IO64_VLD, IO64_OVR, WR_CNT);
    endtask

    task automatic check_ram(input string tag);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s RAM_%0d", tag, i), ram_obs[i], ram_exp[i]);
        end
    endtask

    // One clock of stimulus; outputs are sampled 1 time unit after the edge.
    task automatic cyc(input logic wen, input logic [7:0] ad, input logic [15:0] data, input logic ack);
        @(negedge CLK_WB);
        RAM_WEN = wen;
        RAM_AD_IN = ad;
        RAM_IN = data;
        IO64_ACK = ack;
        @(posedge CLK_WB);
        #1;
        RAM_WEN = 1'b0;
        IO64_ACK = 1'b0;
    endtask

    // Reset asserted between edges and checked before the next rising edge.
    task automatic do_reset(input string tag);
        @(negedge CLK_WB);
        #2 RESET_N = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) ram_exp[i] = 16'h0000;
        check_ram(tag);
        check_port(tag, 16'h0000, 1'b0, 1'b0, 8'd0);
        @(negedge CLK_WB);
        RESET_N = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) ram_exp[i] = 16'h0000;
        RESET_N = 1'b0;
        #12;
        check_ram("reset");
        check_port("reset", 16'h0000, 1'b0, 1'b0, 8'd0);
        @(negedge CLK_WB);
        RESET_N = 1'b1;

        cyc(1'b1, 8'd3, 16'h1234, 1'b0);
        cyc(1'b1, 8'd7, 16'hBEEF, 1'b0);
        ram_exp[3] = 16'h1234;
        ram_exp[7] = 16'hBEEF;
        check_ram("word wr");
        check_port("word wr", 16'h0000, 1'b0, 1'b0, 8'd2);

        cyc(1'b0, 8'd3, 16'hFFFF, 1'b0);
        check_ram("wen low");

        cyc(1'b1, 8'd64, 16'h00AA, 1'b0);
        check_port("port wr", 16'h00AA, 1'b1, 1'b0, 8'd3);
        cyc(1'b0, 8'd0, 16'h0000, 1'b1);
        check_port("port ack", 16'h00AA, 1'b0, 1'b0, 8'd3);
        cyc(1'b0, 8'd0, 16'h0000, 1'b1);
        check_port("idle ack", 16'h00AA, 1'b0, 1'b0, 8'd3);

        cyc(1'b1, 8'd9, 16'h5A5A, 1'b0);
        cyc(1'b1, 8'd65, 16'hA5A5, 1'b0);
        check_ram("bad addr");
        check_port("bad addr", 16'h00AA, 1'b0, 1'b0, 8'd3);

        do_reset("reset2");
        cyc(1'b1, 8'd64, 16'h0001, 1'b0);
        cyc(1'b1, 8'd64, 16'h0002, 1'b0);
        check_port("overrun", 16'h0001, 1'b1, 1'b1, 8'd1);
        cyc(1'b0, 8'd0, 16'h0000, 1'b1);
        check_port("ovr sticky", 16'h0001, 1'b0, 1'b1, 8'd1);
        do_reset("ovr clear");

        cyc(1'b1, 8'd64, 16'h0011, 1'b0);
        cyc(1'b1, 8'd64, 16'h0055, 1'b1);
        check_port("ack+wr", 16'h0055, 1'b1, 1'b0, 8'd2);
        cyc(1'b1, 8'd0, 16'hC0DE, 1'b1);
        ram_exp[0] = 16'hC0DE;
        check_ram("ram+ack");
        check_port("ram+ack", 16'h0055, 1'b0, 1'b0, 8'd3);

        cyc(1'b1, 8'd64, 16'h0077, 1'b0);
        check_port("hold pre", 16'h0077, 1'b1, 1'b0, 8'd4);
        do_reset("mid hold");
        cyc(1'b1, 8'd64, 16'h0099, 1'b0);
        check_port("post rst", 16'h0099, 1'b1, 1'b0, 8'd1);

        do_reset("reset wrap");
        for (int i = 0; i < 255; i++) begin
            @(negedge CLK_WB);
            RAM_WEN = 1'b1;
            RAM_AD_IN = 8'(i % 8);
            RAM_IN = 16'(i);
        end
        @(posedge CLK_WB);
        #1 RAM_WEN = 1'b0;
        check("cnt 255", {8'd0, WR_CNT}, 16'h00FF);
        cyc(1'b1, 8'd5, 16'h0123, 1'b0);
        check("cnt wrap", {8'd0, WR_CNT}, 16'h0000);
        check("last word", RAM_5, 16'h0123);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
